// File: rtl/inst_queue.sv
// Fetch-group instruction queue between I-Cache return and decode.
// Compacts enabled lanes into a circular FIFO and shows the two oldest entries to ID.
module inst_queue #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int STOP_THRESH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              inst_data_ok_i,
  input  logic [127:0]      inst_rdata_i,
  input  logic [31:0]       PCR_VAddr_i,
  input  logic [3:0]        PCR_instEnable_i,
  input  logic              PCR_hasException_i,
  input  logic [4:0]        PCR_ExcCode_i,
  input  logic [1:0]        ID_readNum_i,
  output logic [1:0]        IQ_valid_o,
  output logic [31:0]       IQ_inst0_o,
  output logic [31:0]       IQ_inst1_o,
  output logic [31:0]       IQ_pc0_o,
  output logic [31:0]       IQ_pc1_o,
  output logic [1:0]        IQ_exc_o,
  output logic [4:0]        IQ_excCode0_o,
  output logic [4:0]        IQ_excCode1_o,
  output logic [ADDR_W:0]   IQ_count_o,
  output logic              IQ_stopFetch_o,
  output logic              IQ_overflow_o
);

  localparam logic [ADDR_W+1:0] DEPTH_W  = (ADDR_W+2)'(DEPTH);
  localparam logic [ADDR_W:0]   STOP_LVL = (ADDR_W+1)'(DEPTH - STOP_THRESH);

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  logic [31:0]       inst_mem_r [DEPTH];
  logic [31:0]       pc_mem_r   [DEPTH];
  logic              exc_mem_r  [DEPTH];
  logic [4:0]        code_mem_r [DEPTH];

  logic [ADDR_W-1:0] head_r, tail_r;
  logic [ADDR_W:0]   count_r;
  logic              stop_r, overflow_r, exc_lock_r;

  logic              take_s, drop_s, wr_s;
  logic [2:0]        w_s;
  logic [ADDR_W:0]   rd_ext_s, r_s, count_next_s;
  logic [ADDR_W+1:0] space_s;
  logic [2:0]        off_s       [4];
  logic [ADDR_W-1:0] lane_addr_s [4];
  logic [ADDR_W-1:0] head1_s;

  // write/read sizing; overflow uses the space left after this cycle's read
  always_comb begin
    take_s   = inst_data_ok_i && !flush_i && !exc_lock_r;
    w_s      = 3'd0;
    if (take_s) begin
      w_s = PCR_hasException_i ? 3'd1 : popcount4(PCR_instEnable_i);
    end else begin
      w_s = 3'd0;
    end
    rd_ext_s = (ADDR_W+1)'(ID_readNum_i);
    r_s      = (rd_ext_s > count_r) ? count_r : rd_ext_s;
    space_s  = DEPTH_W - {1'b0, count_r} + {1'b0, r_s};
    drop_s   = take_s && ((ADDR_W+2)'(w_s) > space_s);
    wr_s     = take_s && !drop_s && (w_s != 3'd0);
    count_next_s = count_r + (wr_s ? (ADDR_W+1)'(w_s) : {(ADDR_W+1){1'b0}}) - r_s;
    off_s[0] = 3'd0;
    for (int k = 1; k < 4; k++) begin
      off_s[k] = off_s[k-1] + {2'b00, PCR_instEnable_i[k-1]};
    end
    for (int k = 0; k < 4; k++) begin
      lane_addr_s[k] = tail_r + ADDR_W'(off_s[k]);
    end
  end

  // entry storage: exception groups take one slot, normal groups pack enabled lanes
  always_ff @(posedge clk) begin
    if (wr_s) begin
      if (PCR_hasException_i) begin
        inst_mem_r[tail_r] <= 32'd0;
        pc_mem_r[tail_r]   <= PCR_VAddr_i;
        exc_mem_r[tail_r]  <= 1'b1;
        code_mem_r[tail_r] <= PCR_ExcCode_i;
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (PCR_instEnable_i[k]) begin
            inst_mem_r[lane_addr_s[k]] <= inst_rdata_i[32*k +: 32];
            pc_mem_r[lane_addr_s[k]]   <= {PCR_VAddr_i[31:4], 2'(k), 2'b00};
            exc_mem_r[lane_addr_s[k]]  <= 1'b0;
            code_mem_r[lane_addr_s[k]] <= 5'd0;
          end
        end
      end
    end
  end

  // pointers, occupancy and status flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_r     <= {ADDR_W{1'b0}};
      tail_r     <= {ADDR_W{1'b0}};
      count_r    <= {(ADDR_W+1){1'b0}};
      stop_r     <= 1'b0;
      overflow_r <= 1'b0;
      exc_lock_r <= 1'b0;
    end else if (flush_i) begin
      head_r     <= {ADDR_W{1'b0}};
      tail_r     <= {ADDR_W{1'b0}};
      count_r    <= {(ADDR_W+1){1'b0}};
      stop_r     <= 1'b0;
      exc_lock_r <= 1'b0;
    end else begin
      head_r  <= head_r + r_s[ADDR_W-1:0];
      tail_r  <= wr_s ? (tail_r + ADDR_W'(w_s)) : tail_r;
      count_r <= count_next_s;
      stop_r  <= (count_next_s > STOP_LVL);
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      if (wr_s && PCR_hasException_i) begin
        exc_lock_r <= 1'b1;
      end
    end
  end

  // show-ahead slots; invalid slots read as zero
  always_comb begin
    head1_s       = head_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    IQ_valid_o    = {count_r > (ADDR_W+1)'(1), count_r != {(ADDR_W+1){1'b0}}};
    IQ_inst0_o    = 32'd0;
    IQ_pc0_o      = 32'd0;
    IQ_excCode0_o = 5'd0;
    IQ_inst1_o    = 32'd0;
    IQ_pc1_o      = 32'd0;
    IQ_excCode1_o = 5'd0;
    IQ_exc_o      = 2'b00;
    if (IQ_valid_o[0]) begin
      IQ_inst0_o    = inst_mem_r[head_r];
      IQ_pc0_o      = pc_mem_r[head_r];
      IQ_exc_o[0]   = exc_mem_r[head_r];
      IQ_excCode0_o = code_mem_r[head_r];
    end else begin
      IQ_exc_o[0]   = 1'b0;
    end
    if (IQ_valid_o[1]) begin
      IQ_inst1_o    = inst_mem_r[head1_s];
      IQ_pc1_o      = pc_mem_r[head1_s];
      IQ_exc_o[1]   = exc_mem_r[head1_s];
      IQ_excCode1_o = code_mem_r[head1_s];
    end else begin
      IQ_exc_o[1]   = 1'b0;
    end
    IQ_count_o     = count_r;
    IQ_stopFetch_o = stop_r;
    IQ_overflow_o  = overflow_r;
  end

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: stimulus pushes hand-computed expected state,
// a monitor on the falling edge pops and compares.
module tb_inst_queue;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush_i;
  logic         inst_data_ok_i;
  logic [127:0] inst_rdata_i;
  logic [31:0]  PCR_VAddr_i;
  logic [3:0]   PCR_instEnable_i;
  logic         PCR_hasException_i;
  logic [4:0]   PCR_ExcCode_i;
  logic [1:0]   ID_readNum_i;
  logic [1:0]   IQ_valid_o;
  logic [31:0]  IQ_inst0_o, IQ_inst1_o, IQ_pc0_o, IQ_pc1_o;
  logic [1:0]   IQ_exc_o;
  logic [4:0]   IQ_excCode0_o, IQ_excCode1_o;
  logic [4:0]   IQ_count_o;
  logic         IQ_stopFetch_o, IQ_overflow_o;

  inst_queue dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .inst_data_ok_i(inst_data_ok_i),
    .inst_rdata_i(inst_rdata_i), .PCR_VAddr_i(PCR_VAddr_i),
    .PCR_instEnable_i(PCR_instEnable_i), .PCR_hasException_i(PCR_hasException_i),
    .PCR_ExcCode_i(PCR_ExcCode_i), .ID_readNum_i(ID_readNum_i),
    .IQ_valid_o(IQ_valid_o), .IQ_inst0_o(IQ_inst0_o), .IQ_inst1_o(IQ_inst1_o),
    .IQ_pc0_o(IQ_pc0_o), .IQ_pc1_o(IQ_pc1_o), .IQ_exc_o(IQ_exc_o),
    .IQ_excCode0_o(IQ_excCode0_o), .IQ_excCode1_o(IQ_excCode1_o),
    .IQ_count_o(IQ_count_o), .IQ_stopFetch_o(IQ_stopFetch_o),
    .IQ_overflow_o(IQ_overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    int          cnt;
    logic [31:0] pc0, pc1, inst0;
    logic [1:0]  exc;
    logic [4:0]  code0;
    logic        stop, ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   tag_n  = 0;
  localparam logic [4:0] ADEL = 5'd4;

  task automatic cmp(input int tag, input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL chk%0d %s got %h want %h", tag, nm, act, want);
    end
  endtask

  // monitor: state after each stimulus edge is compared on the following falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp(e.tag, "count", {27'd0, IQ_count_o}, e.cnt);
      cmp(e.tag, "valid", {30'd0, IQ_valid_o}, {30'd0, e.cnt > 1, e.cnt > 0});
      cmp(e.tag, "pc0", IQ_pc0_o, e.pc0);
      cmp(e.tag, "pc1", IQ_pc1_o, e.pc1);
      cmp(e.tag, "inst0", IQ_inst0_o, e.inst0);
      cmp(e.tag, "exc", {30'd0, IQ_exc_o}, {30'd0, e.exc});
      cmp(e.tag, "code0", {27'd0, IQ_excCode0_o}, {27'd0, e.code0});
      cmp(e.tag, "stop", {31'd0, IQ_stopFetch_o}, {31'd0, e.stop});
      cmp(e.tag, "ovf", {31'd0, IQ_overflow_o}, {31'd0, e.ovf});
    end
  end

  task automatic step(input logic ok, input logic [31:0] va, input logic [3:0] en,
                      input logic ex, input logic [4:0] code, input logic [1:0] rd,
                      input logic fl, input logic rs);
    @(negedge clk);
    rst                = rs;
    inst_data_ok_i     = ok;
    PCR_VAddr_i        = va;
    PCR_instEnable_i   = en;
    PCR_hasException_i = ex;
    PCR_ExcCode_i      = code;
    ID_readNum_i       = rd;
    flush_i            = fl;
    inst_rdata_i       = {8'hE3, va[23:0], 8'hE2, va[23:0], 8'hE1, va[23:0], 8'hE0, va[23:0]};
    @(posedge clk);
  endtask

  task automatic grp(input logic [31:0] va, input logic [3:0] en, input logic [1:0] rd);
    step(1'b1, va, en, 1'b0, 5'd0, rd, 1'b0, 1'b1);
  endtask

  task automatic rd_only(input logic [1:0] rd);
    step(1'b0, 32'd0, 4'd0, 1'b0, 5'd0, rd, 1'b0, 1'b1);
  endtask

  task automatic chk(input int cnt, input logic [31:0] pc0, input logic [31:0] pc1,
                     input logic [31:0] inst0, input logic [1:0] exc, input logic [4:0] code0,
                     input logic stop, input logic ovf);
    exp_t e;
    e.tag = tag_n; e.cnt = cnt; e.pc0 = pc0; e.pc1 = pc1; e.inst0 = inst0;
    e.exc = exc; e.code0 = code0; e.stop = stop; e.ovf = ovf;
    tag_n++;
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    rst = 1'b0; flush_i = 1'b0; inst_data_ok_i = 1'b0; inst_rdata_i = 128'd0;
    PCR_VAddr_i = 32'd0; PCR_instEnable_i = 4'd0; PCR_hasException_i = 1'b0;
    PCR_ExcCode_i = 5'd0; ID_readNum_i = 2'd0;
    step(1'b0, 32'd0, 4'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 4'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0);
    chk(0, 32'h0, 32'h0, 32'h0, 2'b00, 5'd0, 1'b0, 1'b0);

    // full group, then drain in pairs
    grp(32'hBFC00000, 4'b1111, 2'd0); chk(4, 32'hBFC00000, 32'hBFC00004, 32'hE0C00000, 2'b00, 5'd0, 1'b0, 1'b0);
    rd_only(2'd2); chk(2, 32'hBFC00008, 32'hBFC0000C, 32'hE2C00000, 2'b00, 5'd0, 1'b0, 1'b0);
    rd_only(2'd2); chk(0, 32'h0, 32'h0, 32'h0, 2'b00, 5'd0, 1'b0, 1'b0);

    // partial masks compact without holes; read request clipped to count
    grp(32'h80000008, 4'b1100, 2'd0); chk(2, 32'h80000008, 32'h8000000C, 32'hE2000008, 2'b00, 5'd0, 1'b0, 1'b0);
    rd_only(2'd2); chk(0, 32'h0, 32'h0, 32'h0, 2'b00, 5'd0, 1'b0, 1'b0);
    grp(32'h80000010, 4'b1010, 2'd0); chk(2, 32'h80000014, 32'h8000001C, 32'hE1000010, 2'b00, 5'd0, 1'b0, 1'b0);
    rd_only(2'd1); chk(1, 32'h8000001C, 32'h0, 32'hE3000010, 2'b00, 5'd0, 1'b0, 1'b0);
    rd_only(2'd2); chk(0, 32'h0, 32'h0, 32'h0, 2'b00, 5'd0, 1'b0, 1'b0);

    // stopFetch threshold around 8/9 entries
    grp(32'h00001000, 4'b1111, 2'd0);
    grp(32'h00002000, 4'b1111, 2'd0); chk(8, 32'h00001000, 32'h00001004, 32'hE0001000, 2'b00, 5'd0, 1'b0, 1'b0);
    grp(32'h00003000, 4'b0001, 2'd0); chk(9, 32'h00001000, 32'h00001004, 32'hE0001000, 2'b00, 5'd0, 1'b1, 1'b0);
    rd_only(2'd2); chk(7, 32'h00001008, 32'h0000100C, 32'hE2001000, 2'b00, 5'd0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 4'd0, 1'b0, 5'd0, 2'd0, 1'b1, 1'b1);
    chk(0, 32'h0, 32'h0, 32'h0, 2'b00, 5'd0, 1'b0, 1'b0);

    // wrap: count 14 at tail 14, accept with post-read space, then overflow
    grp(32'h00004000, 4'b1111, 2'd0);
    grp(32'h00004010, 4'b1111, 2'd0);
    grp(32'h00004020, 4'b1111, 2'd0);
    grp(32'h00004030, 4'b0011, 2'd0); chk(14, 32'h00004000, 32'h00004004, 32'hE0004000, 2'b00, 5'd0, 1'b1, 1'b0);
    grp(32'h00005000, 4'b1111, 2'd2); chk(16, 32'h00004008, 32'h0000400C, 32'hE2004000, 2'b00, 5'd0, 1'b1, 1'b0);
    grp(32'h00006000, 4'b1111, 2'd0); chk(16, 32'h00004008, 32'h0000400C, 32'hE2004000, 2'b00, 5'd0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) rd_only(2'd2);
    chk(4, 32'h00005000, 32'h00005004, 32'hE0005000, 2'b00, 5'd0, 1'b0, 1'b1);
    rd_only(2'd2); chk(2, 32'h00005008, 32'h0000500C, 32'hE2005000, 2'b00, 5'd0, 1'b0, 1'b1);
    rd_only(2'd2); chk(0, 32'h0, 32'h0, 32'h0, 2'b00, 5'd0, 1'b0, 1'b1);

    // exception entry locks the queue until flush
    step(1'b1, 32'h80000102, 4'b1111, 1'b1, ADEL, 2'd0, 1'b0, 1'b1);
    chk(1, 32'h80000102, 32'h0, 32'h0, 2'b01, ADEL, 1'b0, 1'b1);
    grp(32'h80000200, 4'b1111, 2'd0); chk(1, 32'h80000102, 32'h0, 32'h0, 2'b01, ADEL, 1'b0, 1'b1);
    step(1'b0, 32'd0, 4'd0, 1'b0, 5'd0, 2'd0, 1'b1, 1'b1);
    chk(0, 32'h0, 32'h0, 32'h0, 2'b00, 5'd0, 1'b0, 1'b1);
    grp(32'h80000300, 4'b0011, 2'd0); chk(2, 32'h80000300, 32'h80000304, 32'hE0000300, 2'b00, 5'd0, 1'b0, 1'b1);

    // data and flush together at count 5
    grp(32'h80000400, 4'b0111, 2'd0); chk(5, 32'h80000300, 32'h80000304, 32'hE0000300, 2'b00, 5'd0, 1'b0, 1'b1);
    step(1'b1, 32'h80000500, 4'b1111, 1'b0, 5'd0, 2'd0, 1'b1, 1'b1);
    chk(0, 32'h0, 32'h0, 32'h0, 2'b00, 5'd0, 1'b0, 1'b1);
    rd_only(2'd2); chk(0, 32'h0, 32'h0, 32'h0, 2'b00, 5'd0, 1'b0, 1'b1);

    // reset mid-operation wins over flush, write and read; clears overflow
    grp(32'h80000600, 4'b1111, 2'd0); chk(4, 32'h80000600, 32'h80000604, 32'hE0000600, 2'b00, 5'd0, 1'b0, 1'b1);
    step(1'b1, 32'h80000700, 4'b1111, 1'b0, 5'd0, 2'd2, 1'b1, 1'b0);
    chk(0, 32'h0, 32'h0, 32'h0, 2'b00, 5'd0, 1'b0, 1'b0);

    rd_only(2'd0);
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
